alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the ALU port (control/operand1/operand2 -> out, 1-cycle registered result).
//  Accepts one operation per valid/ready request, drives the ALU inputs for exactly one cycle,
//  captures the registered ALU result and returns it on a valid/ready result channel.
//  Rejects unsupported opcodes locally with an error flag. Sits between a command source and the ALU.
// PARAMETERS
//  Width     32  data width; matches the ALU Width
//  OP_CNT_W  16  width of the completed-operation counter
// PORTS
//  clk          in   1         clock; all logic on posedge
//  rst_n        in   1         synchronous active-low reset
//  req_valid    in   1         request present
//  req_ready    out  1         controller can accept a request
//  req_op       in   4         opcode: 0001 add, 0010 sub, 0011 mul, 0100 shl
//  req_a        in   Width     operand1
//  req_b        in   Width     operand2
//  alu_control  out  4         to ALU control
//  alu_op1      out  Width     to ALU operand1
//  alu_op2      out  Width     to ALU operand2
//  alu_out      in   Width     from ALU out (registered in the ALU)
//  res_valid    out  1         result present
//  res_ready    in   1         result consumer ready
//  res_data     out  Width     result (0 when res_err)
//  res_err      out  1         1 = opcode rejected, ALU not issued
//  op_count     out  OP_CNT_W  completed (non-error) operations, wraps to 0
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE; alu_control=0000, alu_op1/op2=0, res_valid=0,
//   res_data=0, res_err=0, op_count=0. Reset overrides any in-flight operation; the result is dropped.
//  All outputs registered except req_ready, which is (state==IDLE).
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE (legal op); IDLE -> DONE (illegal op).
//  IDLE: on req_valid&&req_ready at edge E: legal op -> load alu_control=req_op,
//   alu_op1=req_a, alu_op2=req_b, go ISSUE. Illegal op (0000, 0101..1111) -> res_data=0,
//   res_err=1, res_valid=1, go DONE; ALU inputs untouched.
//  ISSUE (one cycle): ALU samples inputs at edge E+1; controller sets alu_control=0000
//   (ALU holds out), alu_op1/op2 keep their values; go WAIT.
//  WAIT (one cycle): at edge E+2 capture res_data=alu_out, res_err=0, res_valid=1,
//   op_count+=1 (modulo 2^OP_CNT_W); go DONE.
//  DONE: hold res_valid/res_data/res_err stable until res_valid&&res_ready at an edge;
//   then res_valid=0, go IDLE. No new request is accepted in DONE, even when res_ready is high.
//  Latency: legal op accepted at edge E -> res_valid high from edge E+2 (cycle after E+2).
//   Illegal op -> res_valid high after edge E. Max throughput 1 op / 4 cycles (legal op,
//   res_ready held high).
//  Arithmetic is performed in the ALU; the controller passes the low Width bits unchanged.
//  alu_control is 0000 outside ISSUE, so the ALU never sees a repeated issue.
//  req_* values are ignored when req_ready=0; no request is stored.
// TESTING
//  Reset: rst_n=0 for 2 cycles -> all outputs 0, req_ready=1, op_count=0.
//  Add: op=0001, a=5, b=7, res_ready=1 -> alu_control=0001 for exactly 1 cycle;
//   res_data=12, res_err=0 two edges after accept; op_count=1.
//  Backpressure: op=0011, a=3, b=4, res_ready=0 for 5 cycles -> res_valid=1 with res_data=12
//   held stable, req_ready=0 throughout; res_ready=1 -> IDLE next cycle.
//  Sub wrap / shift: a=0, b=1, op=0010 -> 32'hFFFFFFFF; a=1, b=31, op=0100 -> 32'h80000000.
//  Illegal: op=0111 -> res_err=1, res_data=0 one edge after accept; alu_control stays 0000;
//   op_count unchanged.
//  Reset mid-op: rst_n=0 in WAIT -> no res_valid, state IDLE, op_count=0; next op=0001,
//   a=1, b=1 -> res_data=2.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Initiator side of a registered-output ALU port. Accepts one
//               operation per valid/ready request, drives the ALU inputs for
//               a single cycle, captures the ALU result two edges later and
//               returns it on a valid/ready result channel. Unsupported
//               opcodes are answered locally with an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int Width    = 32,
  parameter int OP_CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [Width-1:0]    req_a,
  input  logic [Width-1:0]    req_b,
  output logic [3:0]          alu_control,
  output logic [Width-1:0]    alu_op1,
  output logic [Width-1:0]    alu_op2,
  input  logic [Width-1:0]    alu_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [Width-1:0]    res_data,
  output logic                res_err,
  output logic [OP_CNT_W-1:0] op_count
);

  // Opcodes understood by the ALU; zero is the ALU "hold" code.
  localparam logic [3:0] c_op_nop = 4'b0000;
  localparam logic [3:0] c_op_add = 4'b0001;
  localparam logic [3:0] c_op_shl = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_legal_op;
  logic                  w_accept;
  logic [3:0]            r_alu_control;
  logic [Width-1:0]      r_alu_op1;
  logic [Width-1:0]      r_alu_op2;
  logic                  r_res_valid;
  logic [Width-1:0]      r_res_data;
  logic                  r_res_err;
  logic [OP_CNT_W-1:0]   r_op_count;

  // Legal opcodes form the contiguous range add..shl.
  assign w_legal_op = (req_op >= c_op_add) && (req_op <= c_op_shl);
  assign req_ready  = (r_state == S_IDLE);
  assign w_accept   = req_valid && req_ready;

  assign alu_control = r_alu_control;
  assign alu_op1     = r_alu_op1;
  assign alu_op2     = r_alu_op2;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign res_err     = r_res_err;
  assign op_count    = r_op_count;

  // State register; reset abandons any in-flight operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: legal ops take the ISSUE/WAIT path, illegal ones skip to DONE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = w_legal_op ? S_ISSUE : S_DONE;
        end
      end
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  w_next_state = S_DONE;
      S_DONE: begin
        if (r_res_valid && res_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Registered ALU drive, result capture and completion counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_control <= c_op_nop;
      r_alu_op1     <= '0;
      r_alu_op2     <= '0;
      r_res_valid   <= 1'b0;
      r_res_data    <= '0;
      r_res_err     <= 1'b0;
      r_op_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_legal_op) begin
              r_alu_control <= req_op;
              r_alu_op1     <= req_a;
              r_alu_op2     <= req_b;
            end else begin
              r_res_data  <= '0;
              r_res_err   <= 1'b1;
              r_res_valid <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // ALU has sampled its inputs; drop back to hold so it is not re-issued.
          r_alu_control <= c_op_nop;
        end
        S_WAIT: begin
          r_res_data  <= alu_out;
          r_res_err   <= 1'b0;
          r_res_valid <= 1'b1;
          r_op_count  <= r_op_count + OP_CNT_W'(1);
        end
        S_DONE: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_alu_control <= c_op_nop;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl with a registered ALU
//               model and a specification-level reference for results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  localparam int W  = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic [3:0]    alu_control;
  logic [W-1:0]  alu_op1;
  logic [W-1:0]  alu_op2;
  logic [W-1:0]  alu_out;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic          res_err;
  logic [CW-1:0] op_count;

  int            checks = 0;
  int            errors = 0;
  int            issue_cnt = 0;
  logic [CW-1:0] exp_cnt = '0;

  alu_issue_ctrl #(.Width(W), .OP_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_control(alu_control), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Registered ALU: computes on any non-zero control, holds its output otherwise.
  initial alu_out = '0;
  always @(posedge clk) begin
    if (alu_control != 4'd0) begin
      issue_cnt <= issue_cnt + 1;
      case (alu_control)
        4'd1:    alu_out <= alu_op1 + alu_op2;
        4'd2:    alu_out <= alu_op1 - alu_op2;
        4'd3:    alu_out <= alu_op1 * alu_op2;
        4'd4:    alu_out <= alu_op1 << alu_op2[4:0];
        default: alu_out <= 32'hDEAD_BEEF;
      endcase
    end
  end

  function automatic bit ref_legal(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd4);
  endfunction

  function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint unsigned p;
    case (op)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: begin p = longint'(a) * longint'(b); return p[W-1:0]; end
      4'd4: return a << b[4:0];
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, then waits (bounded) for the result to appear.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] data, output logic err, output int lat,
                        output bit timeout);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0; req_op = $urandom; req_a = $urandom; req_b = $urandom;
    lat = 0;
    timeout = 0;
    while (!res_valid && lat < 10) begin
      tick();
      lat++;
    end
    if (!res_valid) timeout = 1;
    data = res_data;
    err  = res_err;
  endtask

  task automatic drain();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    exp_cnt = '0;
    checks++; if (alu_control !== 4'd0) begin errors++; $display("FAIL reset_alu_control got %0h want 0", alu_control); end
    checks++; if (alu_op1 !== '0 || alu_op2 !== '0) begin errors++; $display("FAIL reset_alu_ops got %0h/%0h want 0/0", alu_op1, alu_op2); end
    checks++; if (res_valid !== 1'b0 || res_err !== 1'b0) begin errors++; $display("FAIL reset_res_flags got v=%b e=%b want 0/0", res_valid, res_err); end
    checks++; if (res_data !== '0) begin errors++; $display("FAIL reset_res_data got %0h want 0", res_data); end
    checks++; if (op_count !== '0) begin errors++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_add();
    res_ready = 1'b1;
    req_valid = 1'b1; req_op = 4'd1; req_a = 32'd5; req_b = 32'd7;
    tick();
    req_valid = 1'b0;
    checks++; if (alu_control !== 4'd1 || alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin errors++; $display("FAIL add_issue got c=%0h a=%0d b=%0d want 1/5/7", alu_control, alu_op1, alu_op2); end
    tick();
    checks++; if (alu_control !== 4'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL add_issue_one_cycle got c=%0h v=%b want 0/0", alu_control, res_valid); end
    checks++; if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7) begin errors++; $display("FAIL add_ops_held got %0d/%0d want 5/7", alu_op1, alu_op2); end
    tick();
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (res_valid !== 1'b1 || res_data !== 32'd12 || res_err !== 1'b0) begin errors++; $display("FAIL add_result got v=%b d=%0d e=%b want 1/12/0", res_valid, res_data, res_err); end
    checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL add_op_count got %0d want %0d", op_count, exp_cnt); end
    tick();
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL add_release got v=%b rdy=%b want 0/1", res_valid, req_ready); end
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d; logic e; int lat; bit to; int ic;
    run_op(4'd3, 32'd3, 32'd4, d, e, lat, to);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (to || d !== 32'd12) begin errors++; $display("FAIL bp_result got d=%0d to=%b want 12/0", d, to); end
    ic = issue_cnt;
    req_valid = 1'b1; req_op = 4'd1; req_a = 32'd9; req_b = 32'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (res_valid !== 1'b1 || res_data !== 32'd12 || req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%0d rdy=%b want 1/12/0", i, res_valid, res_data, req_ready); end
    end
    req_valid = 1'b0;
    checks++; if (issue_cnt != ic) begin errors++; $display("FAIL bp_no_accept got issues %0d want %0d", issue_cnt, ic); end
    drain();
    checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL bp_release got rdy=%b v=%b want 1/0", req_ready, res_valid); end
    checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL bp_op_count got %0d want %0d", op_count, exp_cnt); end
  endtask

  task automatic test_sub_shift();
    logic [W-1:0] d; logic e; int lat; bit to;
    run_op(4'd2, 32'd0, 32'd1, d, e, lat, to);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (to || d !== 32'hFFFF_FFFF || e !== 1'b0) begin errors++; $display("FAIL sub_wrap got d=%0h e=%b want ffffffff/0", d, e); end
    drain();
    run_op(4'd4, 32'd1, 32'd31, d, e, lat, to);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (to || d !== 32'h8000_0000 || e !== 1'b0) begin errors++; $display("FAIL shl_31 got d=%0h e=%b want 80000000/0", d, e); end
    drain();
  endtask

  task automatic test_illegal();
    logic [W-1:0] d; logic e; int lat; bit to; int ic;
    ic = issue_cnt;
    run_op(4'd7, 32'd11, 32'd22, d, e, lat, to);
    checks++; if (to || lat != 0) begin errors++; $display("FAIL illegal_latency got lat=%0d to=%b want 0/0", lat, to); end
    checks++; if (e !== 1'b1 || d !== '0) begin errors++; $display("FAIL illegal_result got e=%b d=%0h want 1/0", e, d); end
    checks++; if (alu_control !== 4'd0 || issue_cnt != ic) begin errors++; $display("FAIL illegal_no_issue got c=%0h issues=%0d want 0/%0d", alu_control, issue_cnt, ic); end
    checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL illegal_op_count got %0d want %0d", op_count, exp_cnt); end
    drain();
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] d; logic e; int lat; bit to;
    req_valid = 1'b1; req_op = 4'd1; req_a = 32'd100; req_b = 32'd200;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = '0;
    checks++; if (res_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== '0) begin errors++; $display("FAIL midrst_state got v=%b rdy=%b cnt=%0d want 0/1/0", res_valid, req_ready, op_count); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL midrst_dropped got v=%b want 0", res_valid); end
    run_op(4'd1, 32'd1, 32'd1, d, e, lat, to);
    exp_cnt = exp_cnt + 1'b1;
    checks++; if (to || d !== 32'd2 || e !== 1'b0) begin errors++; $display("FAIL midrst_next got d=%0d e=%b want 2/0", d, e); end
    drain();
  endtask

  task automatic test_random();
    logic [W-1:0] d; logic e; int lat; bit to; int ic; int hold;
    logic [3:0] op; logic [W-1:0] a; logic [W-1:0] b; bit legal;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      a = $urandom; b = $urandom;
      legal = ref_legal(op);
      ic = issue_cnt;
      run_op(op, a, b, d, e, lat, to);
      if (legal) exp_cnt = exp_cnt + 1'b1;
      checks++; if (to || lat != (legal ? 2 : 0)) begin errors++; $display("FAIL rnd_latency op=%0h got lat=%0d to=%b want %0d", op, lat, to, legal ? 2 : 0); end
      checks++; if (d !== ref_result(op, a, b) || e !== !legal) begin errors++; $display("FAIL rnd_result op=%0h a=%0h b=%0h got d=%0h e=%b want %0h/%b", op, a, b, d, e, ref_result(op, a, b), !legal); end
      checks++; if (issue_cnt != ic + (legal ? 1 : 0)) begin errors++; $display("FAIL rnd_issue_count got %0d want %0d", issue_cnt - ic, legal ? 1 : 0); end
      checks++; if (op_count !== exp_cnt) begin errors++; $display("FAIL rnd_op_count got %0d want %0d", op_count, exp_cnt); end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        tick();
        checks++; if (res_valid !== 1'b1 || res_data !== d || req_ready !== 1'b0) begin errors++; $display("FAIL rnd_hold got v=%b d=%0h rdy=%b want 1/%0h/0", res_valid, res_data, req_ready, d); end
      end
      drain();
      checks++; if (req_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL rnd_release got rdy=%b v=%b want 1/0", req_ready, res_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_sub_shift();
    test_illegal();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
